mdio_arb: RTL
=============

// Module: mdio_arb
// PURPOSE
//  Round-robin arbiter sharing a single MDIO driver (op_exec/op_done command port of mdio_dri) among NUM_REQ requesters
//  (e.g. mdio_ctrl, link-status poller, PHY init sequencer). Serialises one register access at a time, returns read data
//  and ack to the granted requester, and aborts a hung access after TIMEOUT cycles. Sits between requesters and mdio_dri on dri_clk.
// PARAMETERS
//  NUM_REQ   3         number of requesters (2..8)
//  TIMEOUT   16'd4096  dri_clk cycles to wait for op_done before abort (>=2)
// PORTS
//  clk           in   1            dri_clk from mdio_dri; single clock domain
//  rst           in   1            asynchronous, active-high reset
//  req           in   NUM_REQ      per-requester level request; held until its req_done pulse
//  req_rh_wl     in   NUM_REQ      per-requester 1=read, 0=write
//  req_addr      in   5*NUM_REQ    packed register addresses, requester i at [5i+4:5i]
//  req_wr_data   in   16*NUM_REQ   packed write data, requester i at [16i+15:16i]
//  req_done      out  NUM_REQ      one-cycle pulse to the served requester at completion
//  rsp_rd_data   out  16           read data of last completed access (valid with req_done)
//  rsp_rd_ack    out  1            0=PHY acked, 1=no ack (copied from op_rd_ack; forced 1 on timeout)
//  rsp_timeout   out  1            1=last access aborted by timeout (valid with req_done)
//  busy          out  1            1 in any state other than IDLE
//  gnt_id        out  3            index of requester currently/last granted
//  op_exec       out  1            one-cycle start pulse to mdio_dri
//  op_rh_wl      out  1            latched command direction
//  op_addr       out  5            latched register address
//  op_wr_data    out  16           latched write data
//  op_done       in   1            one-cycle completion pulse from mdio_dri
//  op_rd_data    in   16           read data from mdio_dri
//  op_rd_ack     in   1            PHY ack from mdio_dri (0=ack)
// BEHAVIOUR
//  - Reset: state=IDLE; all outputs 0 except rsp_rd_ack=1; last_gnt=NUM_REQ-1 (so requester 0 has first priority); timer=0.
//  - FSM IDLE -> ISSUE -> WAIT -> DONE -> IDLE. All outputs registered.
//  - IDLE: if |req, winner = first i with req[i]=1 searching last_gnt+1, last_gnt+2, ... modulo NUM_REQ; latch
//    op_rh_wl/op_addr/op_wr_data from winner's slice, gnt_id=winner; -> ISSUE. No req: stay.
//  - ISSUE: op_exec=1 for exactly this cycle; timer cleared; -> WAIT.
//  - WAIT: timer increments each cycle. op_done=1: capture rsp_rd_data=op_rd_data (writes: capture anyway),
//    rsp_rd_ack=op_rd_ack, rsp_timeout=0; -> DONE. Else timer==TIMEOUT-1: rsp_rd_data=16'h0000, rsp_rd_ack=1,
//    rsp_timeout=1; -> DONE. op_done and timeout in same cycle: op_done wins.
//  - DONE: req_done[gnt_id]=1 for this cycle only; last_gnt=gnt_id; -> IDLE.
//  - Latency: req seen in IDLE at cycle t -> op_exec at t+1; op_done at cycle u -> req_done at u+1; back in IDLE at u+2.
//  - Requester drops req on the edge after sampling req_done; IDLE arbitration then never re-serves a stale request.
//    Requester holding req after req_done is treated as a new request (round-robin places it last).
//  - req[gnt_id] dropped during ISSUE/WAIT: access completes normally, req_done still pulsed; command fields are latched,
//    so later changes on req_* inputs have no effect on the in-flight access.
//  - op_done outside WAIT is ignored. Only one access is ever outstanding.
//  - rsp_* and gnt_id hold their values until the next completion / grant.
//  - Reset mid-operation: immediate return to reset values; op_exec never pulses on reset release without a new grant.
// TESTING
//  1 Single read: req=3'b001, addr0=5'h01, rh_wl=1; model returns 16'h796D ack=0 after 40 cycles -> one op_exec,
//    op_addr=5'h01, req_done=3'b001, rsp_rd_data=16'h796D, rsp_rd_ack=0, rsp_timeout=0.
//  2 Round-robin: req=3'b111 held, each re-requesting after done -> grant order 0,1,2,0,1,2; no requester served twice in a row.
//  3 Write path: requester 2 write addr 5'h00 data 16'h9140 -> op_rh_wl=0, op_wr_data=16'h9140, req_done=3'b100.
//  4 Timeout: TIMEOUT=16, model never asserts op_done -> req_done exactly 16 cycles after ISSUE cycle+1, rsp_timeout=1,
//    rsp_rd_ack=1, rsp_rd_data=0; next request served normally.
//  5 Simultaneous op_done and timeout on cycle TIMEOUT-1 -> rsp_timeout=0, data from op_rd_data.
//  6 Assert rst during WAIT -> busy=0, op_exec=0, req_done=0 immediately; after release, requester 0 wins with req=3'b111.

Source files
------------

// File: rtl/mdio_arb.sv
// mdio_arb: round-robin arbiter that shares one mdio_dri command port among
// NUM_REQ requesters. One register access is in flight at a time. The command
// fields are latched at grant, the read data and ack are returned to the winner,
// and an access with no op_done is aborted after TIMEOUT cycles.
module mdio_arb #(
  parameter int          NUM_REQ = 3,
  parameter logic [15:0] TIMEOUT = 16'd4096
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ-1:0]    req_rh_wl,
  input  logic [5*NUM_REQ-1:0]  req_addr,
  input  logic [16*NUM_REQ-1:0] req_wr_data,
  output logic [NUM_REQ-1:0]    req_done,
  output logic [15:0]           rsp_rd_data,
  output logic                  rsp_rd_ack,
  output logic                  rsp_timeout,
  output logic                  busy,
  output logic [2:0]            gnt_id,
  output logic                  op_exec,
  output logic                  op_rh_wl,
  output logic [4:0]            op_addr,
  output logic [15:0]           op_wr_data,
  input  logic                  op_done,
  input  logic [15:0]           op_rd_data,
  input  logic                  op_rd_ack
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t       r_state;
  state_t       w_stateNxt;
  logic [2:0]   r_lastGnt;
  logic [2:0]   w_lastGntNxt;
  logic [15:0]  r_timer;
  logic [15:0]  w_timerNxt;

  logic               w_found;
  logic [2:0]         w_winner;
  logic [NUM_REQ-1:0] w_gntOneHot;

  logic               w_busyNxt;
  logic [2:0]         w_gntIdNxt;
  logic               w_opExecNxt;
  logic               w_opRhWlNxt;
  logic [4:0]         w_opAddrNxt;
  logic [15:0]        w_opWrDataNxt;
  logic [NUM_REQ-1:0] w_reqDoneNxt;
  logic [15:0]        w_rspRdDataNxt;
  logic               w_rspRdAckNxt;
  logic               w_rspTimeoutNxt;

  // Round-robin pick: requesters above the last grant beat those at or below it,
  // and within each group the lowest index wins (later assignment overrides).
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i] && (i <= int'(r_lastGnt))) begin
        w_found  = 1'b1;
        w_winner = 3'(i);
      end
    end
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i] && (i > int'(r_lastGnt))) begin
        w_found  = 1'b1;
        w_winner = 3'(i);
      end
    end
  end

  // Decode the current grant into the completion pulse vector.
  always_comb begin
    w_gntOneHot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_gntOneHot[i] = (gnt_id == 3'(i));
    end
  end

  // Next-state and next-output logic; every output is the registered copy of these.
  always_comb begin
    w_stateNxt      = r_state;
    w_lastGntNxt    = r_lastGnt;
    w_timerNxt      = r_timer;
    w_gntIdNxt      = gnt_id;
    w_opExecNxt     = 1'b0;
    w_opRhWlNxt     = op_rh_wl;
    w_opAddrNxt     = op_addr;
    w_opWrDataNxt   = op_wr_data;
    w_reqDoneNxt    = '0;
    w_rspRdDataNxt  = rsp_rd_data;
    w_rspRdAckNxt   = rsp_rd_ack;
    w_rspTimeoutNxt = rsp_timeout;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_stateNxt    = ISSUE;
          w_gntIdNxt    = w_winner;
          w_opExecNxt   = 1'b1;
          w_opRhWlNxt   = req_rh_wl[w_winner];
          w_opAddrNxt   = req_addr[5*int'(w_winner) +: 5];
          w_opWrDataNxt = req_wr_data[16*int'(w_winner) +: 16];
        end
      end
      ISSUE: begin
        w_timerNxt = '0;
        w_stateNxt = WAIT;
      end
      WAIT: begin
        w_timerNxt = r_timer + 16'd1;
        if (op_done) begin
          w_rspRdDataNxt  = op_rd_data;
          w_rspRdAckNxt   = op_rd_ack;
          w_rspTimeoutNxt = 1'b0;
          w_reqDoneNxt    = w_gntOneHot;
          w_stateNxt      = DONE;
        end else if (r_timer == (TIMEOUT - 16'd1)) begin
          w_rspRdDataNxt  = 16'h0000;
          w_rspRdAckNxt   = 1'b1;
          w_rspTimeoutNxt = 1'b1;
          w_reqDoneNxt    = w_gntOneHot;
          w_stateNxt      = DONE;
        end
      end
      DONE: begin
        w_lastGntNxt = gnt_id;
        w_stateNxt   = IDLE;
      end
      default: begin
        w_stateNxt = IDLE;
      end
    endcase
    w_busyNxt = (w_stateNxt != IDLE);
  end

  // State, arbitration history and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_lastGnt   <= 3'(NUM_REQ - 1);
      r_timer     <= '0;
      busy        <= 1'b0;
      gnt_id      <= '0;
      op_exec     <= 1'b0;
      op_rh_wl    <= 1'b0;
      op_addr     <= '0;
      op_wr_data  <= '0;
      req_done    <= '0;
      rsp_rd_data <= '0;
      rsp_rd_ack  <= 1'b1;
      rsp_timeout <= 1'b0;
    end else begin
      r_state     <= w_stateNxt;
      r_lastGnt   <= w_lastGntNxt;
      r_timer     <= w_timerNxt;
      busy        <= w_busyNxt;
      gnt_id      <= w_gntIdNxt;
      op_exec     <= w_opExecNxt;
      op_rh_wl    <= w_opRhWlNxt;
      op_addr     <= w_opAddrNxt;
      op_wr_data  <= w_opWrDataNxt;
      req_done    <= w_reqDoneNxt;
      rsp_rd_data <= w_rspRdDataNxt;
      rsp_rd_ack  <= w_rspRdAckNxt;
      rsp_timeout <= w_rspTimeoutNxt;
    end
  end

endmodule
